audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
Parametrised stereo audio serial transmitter for the codec DAC path. It derives BCK and LRCK from the reference clock and serialises left/right PCM samples MSB-first onto the data line. Three runtime-selectable formats are supported: I2S, left-justified and right-justified. Samples arrive through a one-deep holding register with a valid/ready handshake, and underrun is detected and flagged.

Parameters:
REF_CLK, 18432000, reference clock frequency in Hz.
SAMPLE_RATE, 48000, frame rate in Hz.
DATA_WIDTH, 16, PCM bits per channel.
SLOT_WIDTH, 16, BCK periods per channel slot; must be >= DATA_WIDTH.
BCK_DIV_MAX, REF_CLK/(SAMPLE_RATE*SLOT_WIDTH*4)-1, last value of the half-BCK divider (integer truncation); must be >= 0.

Ports:
iCLK  in  1  system/reference clock.
iRST  in  1  reset; synchronous, active-high.
iEN  in  1  run enable.
iMODE  in  2  format: 0=I2S, 1=left-justified, 2=right-justified, 3=treated as I2S.
iDATA_L  in  DATA_WIDTH  left sample.
iDATA_R  in  DATA_WIDTH  right sample.
iVALID  in  1  sample pair valid.
oREADY  out  1  holding register empty (= ~hold_full).
oAUD_BCK  out  1  bit clock.
oAUD_LRCK  out  1  word clock: 0=left slot, 1=right slot.
oAUD_DATA  out  1  serial data; changes only with BCK falling.
oFRAME_START  out  1  one-cycle pulse on the frame-load cycle.
oUNDERRUN  out  1  one-cycle pulse when a frame loads with no sample available.

Behaviour:
- Reset (iRST=1 at posedge iCLK):
  - div=0, oAUD_BCK=0, oAUD_LRCK=0, oAUD_DATA=0.
  - Bit index n=2*SLOT_WIDTH-1.
  - hold_full=0 (oREADY=1); frame L/R registers=0; prev_r_lsb=0.
  - oFRAME_START=0, oUNDERRUN=0; latched mode=I2S.
  - Reset takes effect mid-frame with no completion of the frame.
- iEN=0:
  - div, n and BCK return to their reset values on the next cycle.
  - oAUD_LRCK and oAUD_DATA go to 0 on the next cycle.
  - Holding register and handshake stay operational.
- Divider:
  - Each enabled cycle, div increments.
  - When div==BCK_DIV_MAX: div<=0 and oAUD_BCK toggles.
  - A toggle from 1 to 0 is a bit event.
  - Defaults: 6 cycles per half-BCK; 384 cycles per frame.
- Bit event:
  - n <= (n==2*SLOT_WIDTH-1) ? 0 : n+1.
  - oAUD_LRCK <= (new n >= SLOT_WIDTH).
  - oAUD_DATA <= bit selected for new n (mapping below).
  - First bit event after reset/enable is 2*(BCK_DIV_MAX+1) cycles after enable and is a frame load.
- Frame load (bit event where n becomes 0):
  - Before loading, capture prev_r_lsb from frame R bit 0; latch iMODE.
  - If hold_full: frame <= holding and hold_full<=0.
  - Else if iVALID on the same cycle: frame <= iDATA_L/iDATA_R directly (bypass, no underrun).
  - Else: frame <= 0 and oUNDERRUN=1.
  - oFRAME_START=1 on this cycle.
- Bit mapping, for slot s (L for n<SLOT_WIDTH, R otherwise) and k = n mod SLOT_WIDTH:
  - Left-justified: k<DATA_WIDTH → bit DATA_WIDTH-1-k; otherwise 0.
  - Right-justified: k>=SLOT_WIDTH-DATA_WIDTH → bit SLOT_WIDTH-1-k; otherwise 0.
  - I2S: left-justified shifted one BCK later. Bit at k is the left-justified bit of position k-1 within the same slot. At k=0 it is the previous slot's last left-justified bit; at n=0 that is prev_r_lsb (0 if SLOT_WIDTH>DATA_WIDTH).
- Handshake:
  - Transfer occurs when iVALID && oREADY; the sample is written to holding and hold_full<=1.
  - Transfer on a load cycle with holding empty goes to the frame (bypass); hold_full stays 0.
  - While hold_full=1, inputs are ignored.
- Mode changes between frames take effect at the next frame load only.

Test Plan:
- Defaults, I2S, L=16'hA5F0, R=16'h0F0F loaded before the first frame → BCK period 12 cycles, LRCK period 384 cycles. Data carries A5F0 MSB-first at n=1..16 and 0F0F bits 15..1 at n=17..31. R bit 0 (1) appears at n=0 of the next frame. oREADY returns to 1 on the load cycle.
- Left-justified, same samples → A5F0 at n=0..15, 0F0F at n=16..31, LRCK edges aligned with the MSBs.
- Right-justified, SLOT_WIDTH=24, L=16'h8001 → n=0..7 data 0, n=8 data 1, n=9..22 data 0, n=23 data 1. LRCK period 48 BCK.
- No iVALID ever → oAUD_DATA constantly 0, oUNDERRUN and oFRAME_START pulse every 384 cycles, oREADY held at 1.
- Two pairs presented back-to-back → first accepted (oREADY drops), second stalls until the next frame load, then accepted the cycle after. iVALID asserted exactly on a load cycle with holding empty → sample transmitted in that frame, no underrun.
- iRST or iEN=0 asserted at n=10 → next cycle BCK=LRCK=DATA=0. After release, the first frame starts 12 cycles later with n=0.

Source files
------------

// File: rtl/audio_i2s_tx_if.sv
// Sample handshake between the PCM source and the audio serial transmitter.
// The source drives one stereo pair with valid; the transmitter returns ready while its holding register is empty.
interface audio_i2s_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_l;
  logic [DATA_WIDTH-1:0] data_r;

  modport master (output valid, output data_l, output data_r, input ready);
  modport slave  (input valid, input data_l, input data_r, output ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// Stereo I2S / left-justified / right-justified DAC transmitter.
// BCK and LRCK are derived from the reference clock; samples pass through a one-deep holding register.
module audio_i2s_tx #(
  parameter int REF_CLK     = 18432000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DATA_WIDTH  = 16,
  parameter int SLOT_WIDTH  = 16,
  parameter int BCK_DIV_MAX = REF_CLK / (SAMPLE_RATE * SLOT_WIDTH * 4) - 1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iEN,
  input  logic [1:0]           iMODE,
  audio_i2s_tx_if.slave        smp,
  output logic                 oAUD_BCK,
  output logic                 oAUD_LRCK,
  output logic                 oAUD_DATA,
  output logic                 oFRAME_START,
  output logic                 oUNDERRUN
);

  localparam int NW   = $clog2(2 * SLOT_WIDTH);
  localparam int DIVW = (BCK_DIV_MAX > 0) ? $clog2(BCK_DIV_MAX + 1) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCK_DIV_MAX);
  localparam logic [NW-1:0]   N_LAST   = NW'(2 * SLOT_WIDTH - 1);
  localparam logic [NW-1:0]   N_SLOT   = NW'(SLOT_WIDTH);

  typedef enum logic [1:0] {
    FMT_I2S = 2'd0,
    FMT_LJ  = 2'd1,
    FMT_RJ  = 2'd2
  } fmt_t;

  logic [DIVW-1:0]       div;
  logic [NW-1:0]         n;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic [DATA_WIDTH-1:0] frame_l, frame_r;
  logic                  prev_r_lsb;
  fmt_t                  mode_q;

  logic                  div_wrap;
  logic                  frame_wrap;
  logic                  bit_event;
  logic                  load_event;
  logic                  bypass;
  logic [NW-1:0]         n_next;
  logic [DATA_WIDTH-1:0] ld_l, ld_r;
  logic [DATA_WIDTH-1:0] nx_l, nx_r;
  fmt_t                  ld_mode, nx_mode;
  logic                  nx_prev;
  logic                  nx_bit;

  function automatic logic lj_bit(input logic [DATA_WIDTH-1:0] s, input int k);
    logic [DATA_WIDTH-1:0] t;
    t = s >> (DATA_WIDTH - 1 - k);
    return (k >= 0 && k < DATA_WIDTH) ? t[0] : 1'b0;
  endfunction

  function automatic logic rj_bit(input logic [DATA_WIDTH-1:0] s, input int k);
    logic [DATA_WIDTH-1:0] t;
    t = s >> (SLOT_WIDTH - 1 - k);
    return (k >= SLOT_WIDTH - DATA_WIDTH && k < SLOT_WIDTH) ? t[0] : 1'b0;
  endfunction

  // I2S is the left-justified stream delayed by one BCK; slot position 0 borrows the previous slot's last bit.
  function automatic logic sel_bit(input fmt_t f, input logic [NW-1:0] nn,
                                   input logic [DATA_WIDTH-1:0] l,
                                   input logic [DATA_WIDTH-1:0] r,
                                   input logic prev);
    int                    ni;
    int                    k;
    logic                  right;
    logic [DATA_WIDTH-1:0] s;
    ni    = int'(nn);
    right = (ni >= SLOT_WIDTH);
    k     = right ? ni - SLOT_WIDTH : ni;
    s     = right ? r : l;
    case (f)
      FMT_LJ:  return lj_bit(s, k);
      FMT_RJ:  return rj_bit(s, k);
      default: begin
        if (k > 0)      return lj_bit(s, k - 1);
        else if (right) return lj_bit(l, SLOT_WIDTH - 1);
        else            return (SLOT_WIDTH == DATA_WIDTH) ? prev : 1'b0;
      end
    endcase
  endfunction

  assign smp.ready = ~hold_full;

  always_comb begin
    div_wrap   = (div == DIV_LAST);
    frame_wrap = (n == N_LAST);
    bit_event  = iEN && div_wrap && oAUD_BCK;
    load_event = bit_event && frame_wrap;
    bypass     = load_event && !hold_full && smp.valid;
    n_next     = frame_wrap ? '0 : n + 1'b1;

    case (iMODE)
      2'd1:    ld_mode = FMT_LJ;
      2'd2:    ld_mode = FMT_RJ;
      default: ld_mode = FMT_I2S;
    endcase

    if (hold_full) begin
      ld_l = hold_l;
      ld_r = hold_r;
    end else if (smp.valid) begin
      ld_l = smp.data_l;
      ld_r = smp.data_r;
    end else begin
      ld_l = '0;
      ld_r = '0;
    end

    nx_l    = frame_wrap ? ld_l : frame_l;
    nx_r    = frame_wrap ? ld_r : frame_r;
    nx_mode = frame_wrap ? ld_mode : mode_q;
    nx_prev = frame_wrap ? frame_r[0] : prev_r_lsb;
    nx_bit  = sel_bit(nx_mode, n_next, nx_l, nx_r, nx_prev);
  end

  // Clock generation, serialiser and frame load share one register block so every output is registered.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      div          <= '0;
      n            <= N_LAST;
      oAUD_BCK     <= 1'b0;
      oAUD_LRCK    <= 1'b0;
      oAUD_DATA    <= 1'b0;
      oFRAME_START <= 1'b0;
      oUNDERRUN    <= 1'b0;
      hold_full    <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      frame_l      <= '0;
      frame_r      <= '0;
      prev_r_lsb   <= 1'b0;
      mode_q       <= FMT_I2S;
    end else begin
      oFRAME_START <= 1'b0;
      oUNDERRUN    <= 1'b0;

      if (!iEN) begin
        div       <= '0;
        n         <= N_LAST;
        oAUD_BCK  <= 1'b0;
        oAUD_LRCK <= 1'b0;
        oAUD_DATA <= 1'b0;
      end else if (div_wrap) begin
        div      <= '0;
        oAUD_BCK <= ~oAUD_BCK;
        if (oAUD_BCK) begin
          n         <= n_next;
          oAUD_LRCK <= (n_next >= N_SLOT);
          oAUD_DATA <= nx_bit;
          if (frame_wrap) begin
            frame_l      <= ld_l;
            frame_r      <= ld_r;
            mode_q       <= ld_mode;
            prev_r_lsb   <= frame_r[0];
            oFRAME_START <= 1'b1;
            oUNDERRUN    <= !hold_full && !smp.valid;
          end
        end
      end else begin
        div <= div + 1'b1;
      end

      // A pair offered on a load cycle with the holding register empty goes straight into the frame.
      if (load_event && hold_full) begin
        hold_full <= 1'b0;
      end else if (smp.valid && !hold_full && !bypass) begin
        hold_l    <= smp.data_l;
        hold_r    <= smp.data_r;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: default 16-bit slots on dut_a, 24-bit slots on dut_b.
module tb_audio_i2s_tx;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] exp_f0;
    logic [63:0] exp_f1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [1:0] mode_a, mode_b;
  logic       bck_a, lrck_a, dat_a, fs_a, ur_a;
  logic       bck_b, lrck_b, dat_b, fs_b, ur_b;

  int          compared   = 0;
  int          mismatched = 0;
  logic        data_seen_a;
  int          cnt;
  logic [63:0] dw, lw;
  vec_t        vecs [5];

  always #5 clk = ~clk;

  audio_i2s_tx_if #(.DATA_WIDTH(16)) bus_a ();
  audio_i2s_tx_if #(.DATA_WIDTH(16)) bus_b ();

  audio_i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(16)) dut_a (
    .iCLK(clk), .iRST(rst), .iEN(en_a), .iMODE(mode_a), .smp(bus_a),
    .oAUD_BCK(bck_a), .oAUD_LRCK(lrck_a), .oAUD_DATA(dat_a),
    .oFRAME_START(fs_a), .oUNDERRUN(ur_a)
  );

  audio_i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(24)) dut_b (
    .iCLK(clk), .iRST(rst), .iEN(en_b), .iMODE(mode_b), .smp(bus_b),
    .oAUD_BCK(bck_b), .oAUD_LRCK(lrck_b), .oAUD_DATA(dat_b),
    .oFRAME_START(fs_b), .oUNDERRUN(ur_b)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 64'(act), 64'(exp));
  endtask

  task automatic doReset();
    rst         = 1'b1;
    en_a        = 1'b0;
    en_b        = 1'b0;
    bus_a.valid = 1'b0;
    bus_b.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input bit use_b, input logic [15:0] l, input logic [15:0] r);
    if (use_b) begin
      bus_b.data_l = l;
      bus_b.data_r = r;
      bus_b.valid  = 1'b1;
    end else begin
      bus_a.data_l = l;
      bus_a.data_r = r;
      bus_a.valid  = 1'b1;
    end
    @(negedge clk);
    bus_a.valid = 1'b0;
    bus_b.valid = 1'b0;
  endtask

  task automatic waitFrame(input bit use_b, output int c);
    logic found;
    found = 1'b0;
    c     = 0;
    while (!found && c < 1000) begin
      @(negedge clk);
      c++;
      found = use_b ? fs_b : fs_a;
      if (!use_b) data_seen_a = data_seen_a | dat_a;
    end
    checkBit("frame_start_seen", found, 1'b1);
  endtask

  task automatic captureFrame(input bit use_b, input int bits, input int bck_cyc,
                              output logic [63:0] d, output logic [63:0] lr);
    d  = '0;
    lr = '0;
    for (int i = 0; i < bits; i++) begin
      d  = {d[62:0],  use_b ? dat_b  : dat_a};
      lr = {lr[62:0], use_b ? lrck_b : lrck_a};
      repeat (bck_cyc) @(negedge clk);
    end
  endtask

  task automatic measureBck(input bit use_b, output int per);
    int guard;
    guard = 0;
    per   = 0;
    while ((use_b ? bck_b : bck_a) !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
    while ((use_b ? bck_b : bck_a) !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    while ((use_b ? bck_b : bck_a) === 1'b1 && per < 100) begin @(negedge clk); per++; end
    while ((use_b ? bck_b : bck_a) === 1'b0 && per < 100) begin @(negedge clk); per++; end
  endtask

  initial begin
    rst          = 1'b1;
    en_a         = 1'b0;
    en_b         = 1'b0;
    mode_a       = 2'd0;
    mode_b       = 2'd2;
    bus_a.valid  = 1'b0;
    bus_a.data_l = '0;
    bus_a.data_r = '0;
    bus_b.valid  = 1'b0;
    bus_b.data_l = '0;
    bus_b.data_r = '0;
    data_seen_a  = 1'b0;

    // Frame words are MSB = n0; I2S words start with the previous R lsb.
    vecs[0] = '{2'd0, 16'hA5F0, 16'h0F0F, 64'h52F8_0787, 64'h8000_0000};
    vecs[1] = '{2'd1, 16'hA5F0, 16'h0F0F, 64'hA5F0_0F0F, 64'h0000_0000};
    vecs[2] = '{2'd3, 16'h8001, 16'hC003, 64'h4000_E001, 64'h8000_0000};
    vecs[3] = '{2'd2, 16'h1234, 16'hABCD, 64'h1234_ABCD, 64'h0000_0000};
    vecs[4] = '{2'd0, 16'hFFFF, 16'hFFFE, 64'h7FFF_FFFF, 64'h0000_0000};

    doReset();
    checkOutput("reset_state", 64'({bck_a, lrck_a, dat_a, bus_a.ready, fs_a, ur_a}), 64'b000100);

    for (int i = 0; i < 5; i++) begin
      doReset();
      mode_a = vecs[i].mode;
      applyStimulus(1'b0, vecs[i].l, vecs[i].r);
      checkBit($sformatf("v%0d_ready_low", i), bus_a.ready, 1'b0);
      en_a = 1'b1;
      waitFrame(1'b0, cnt);
      checkOutput($sformatf("v%0d_first_load", i), 64'(cnt), 64'd12);
      checkBit($sformatf("v%0d_ready_on_load", i), bus_a.ready, 1'b1);
      checkBit($sformatf("v%0d_no_underrun", i), ur_a, 1'b0);
      captureFrame(1'b0, 32, 12, dw, lw);
      checkOutput($sformatf("v%0d_frame0_data", i), dw, vecs[i].exp_f0);
      checkOutput($sformatf("v%0d_lrck", i), lw, 64'h0000_FFFF);
      checkBit($sformatf("v%0d_frame1_start", i), fs_a, 1'b1);
      checkBit($sformatf("v%0d_frame1_underrun", i), ur_a, 1'b1);
      captureFrame(1'b0, 32, 12, dw, lw);
      checkOutput($sformatf("v%0d_frame1_data", i), dw, vecs[i].exp_f1);
    end

    $display("[TB] starvation: no samples offered");
    doReset();
    mode_a      = 2'd0;
    en_a        = 1'b1;
    data_seen_a = 1'b0;
    waitFrame(1'b0, cnt);
    checkOutput("starve_first_load", 64'(cnt), 64'd12);
    for (int f = 0; f < 3; f++) begin
      checkBit($sformatf("starve_underrun_%0d", f), ur_a, 1'b1);
      checkBit($sformatf("starve_ready_%0d", f), bus_a.ready, 1'b1);
      waitFrame(1'b0, cnt);
      checkOutput($sformatf("starve_period_%0d", f), 64'(cnt), 64'd384);
    end
    checkBit("starve_data_quiet", data_seen_a, 1'b0);
    measureBck(1'b0, cnt);
    checkOutput("bck_period_a", 64'(cnt), 64'd12);

    $display("[TB] back-to-back pairs");
    doReset();
    mode_a       = 2'd0;
    bus_a.data_l = 16'h1111;
    bus_a.data_r = 16'h2222;
    bus_a.valid  = 1'b1;
    @(negedge clk);
    checkBit("b2b_first_accepted", bus_a.ready, 1'b0);
    bus_a.data_l = 16'h3333;
    bus_a.data_r = 16'h4444;
    repeat (3) @(negedge clk);
    checkBit("b2b_second_stalled", bus_a.ready, 1'b0);
    en_a = 1'b1;
    waitFrame(1'b0, cnt);
    checkBit("b2b_ready_on_load", bus_a.ready, 1'b1);
    checkBit("b2b_load0_no_underrun", ur_a, 1'b0);
    captureFrame(1'b0, 32, 12, dw, lw);
    checkOutput("b2b_frame0_data", dw, 64'h0888_9111);
    checkBit("b2b_frame1_start", fs_a, 1'b1);
    checkBit("b2b_load1_no_underrun", ur_a, 1'b0);
    bus_a.valid = 1'b0;
    captureFrame(1'b0, 32, 12, dw, lw);
    checkOutput("b2b_frame1_data", dw, 64'h1999_A222);

    $display("[TB] bypass on the load cycle");
    doReset();
    mode_a = 2'd1;
    en_a   = 1'b1;
    repeat (11) @(negedge clk);
    bus_a.data_l = 16'hC3C3;
    bus_a.data_r = 16'h3C3C;
    bus_a.valid  = 1'b1;
    @(negedge clk);
    checkBit("bypass_frame_start", fs_a, 1'b1);
    checkBit("bypass_no_underrun", ur_a, 1'b0);
    checkBit("bypass_hold_empty", bus_a.ready, 1'b1);
    bus_a.valid = 1'b0;
    captureFrame(1'b0, 32, 12, dw, lw);
    checkOutput("bypass_frame_data", dw, 64'hC3C3_3C3C);
    checkBit("bypass_next_underrun", ur_a, 1'b1);

    $display("[TB] reset mid-frame");
    doReset();
    mode_a = 2'd0;
    applyStimulus(1'b0, 16'hA5F0, 16'h0F0F);
    en_a = 1'b1;
    waitFrame(1'b0, cnt);
    repeat (10 * 12) @(negedge clk);
    checkBit("rst_abort_data_n10", dat_a, 1'b1);
    repeat (7) @(negedge clk);
    checkBit("rst_abort_bck_high", bck_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_abort_outputs", 64'({bck_a, lrck_a, dat_a}), 64'd0);
    rst = 1'b0;
    waitFrame(1'b0, cnt);
    checkOutput("rst_restart_latency", 64'(cnt), 64'd12);
    checkBit("rst_restart_data_n0", dat_a, 1'b0);
    checkBit("rst_restart_underrun", ur_a, 1'b1);

    $display("[TB] enable drop mid-frame");
    doReset();
    mode_a = 2'd0;
    applyStimulus(1'b0, 16'hA5F0, 16'h0F0F);
    en_a = 1'b1;
    waitFrame(1'b0, cnt);
    repeat (21 * 12) @(negedge clk);
    checkBit("en_abort_data_n21", dat_a, 1'b1);
    checkBit("en_abort_lrck_n21", lrck_a, 1'b1);
    repeat (7) @(negedge clk);
    checkBit("en_abort_bck_high", bck_a, 1'b1);
    en_a = 1'b0;
    @(negedge clk);
    checkOutput("en_abort_outputs", 64'({bck_a, lrck_a, dat_a}), 64'd0);
    repeat (3) @(negedge clk);
    en_a = 1'b1;
    waitFrame(1'b0, cnt);
    checkOutput("en_restart_latency", 64'(cnt), 64'd12);
    checkBit("en_restart_prev_lsb", dat_a, 1'b1);
    checkBit("en_restart_lrck", lrck_a, 1'b0);
    checkBit("en_restart_underrun", ur_a, 1'b1);

    $display("[TB] right-justified, 24-bit slots");
    doReset();
    mode_b = 2'd2;
    applyStimulus(1'b1, 16'h8001, 16'h0003);
    checkBit("rj24_ready_low", bus_b.ready, 1'b0);
    en_b = 1'b1;
    waitFrame(1'b1, cnt);
    checkOutput("rj24_first_load", 64'(cnt), 64'd8);
    captureFrame(1'b1, 48, 8, dw, lw);
    checkOutput("rj24_frame_data", dw, 64'h0000_0080_0100_0003);
    checkOutput("rj24_lrck", lw, 64'h0000_0000_00FF_FFFF);
    checkBit("rj24_frame_period", fs_b, 1'b1);
    checkBit("rj24_next_underrun", ur_b, 1'b1);
    measureBck(1'b1, cnt);
    checkOutput("bck_period_b", 64'(cnt), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
